disp_sr_rx: RTL and testbench

- Serial receiver for the display shift-register link (disp_lat / disp_sclk / disp_sin).
- Deserializes one frame per latch pulse into a parallel word.
- Used as a loopback monitor on the board pins and as the display-side model in system benches.
- Frame format: one disp_lat high pulse, then WIDTH bits, MSB first, each sampled on a disp_sclk rising edge.

---
 rtl/disp_sr_rx.sv | 152 +++++++++++++++
 tb/tb_disp_sr_rx.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/disp_sr_rx.sv
// Display shift-register link receiver: deserializes one MSB-first frame per latch pulse.
// Frame words appear on rx_data with a one-cycle rx_valid strobe; framing faults pulse rx_short_err / rx_over_err.
module disp_sr_rx #(
  parameter int WIDTH       = 256,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_sclk,
  input  logic             disp_lat,
  input  logic             disp_sin,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             rx_short_err,
  output logic             rx_over_err,
  output logic             rx_busy,
  output logic [15:0]      frame_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, OVER} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sr;
  logic [TW-1:0]    tmr;
  logic             frame_done, done_n;

  logic [SYNC_STAGES-1:0] sclk_sync, lat_sync, sin_sync;
  logic                   sclk_hist, lat_hist;
  logic                   sclk_s, lat_s, sin_s;
  logic                   sclk_rise, lat_rise;

  logic shift_en, capture, short_p, over_p, timeout;

  // All three inputs share the same depth so sin stays aligned with the sclk edge it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      lat_sync  <= '0;
      sin_sync  <= '0;
      sclk_hist <= 1'b0;
      lat_hist  <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], disp_sclk};
      lat_sync  <= {lat_sync[SYNC_STAGES-2:0], disp_lat};
      sin_sync  <= {sin_sync[SYNC_STAGES-2:0], disp_sin};
      sclk_hist <= sclk_s;
      lat_hist  <= lat_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign lat_s     = lat_sync[SYNC_STAGES-1];
  assign sin_s     = sin_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign lat_rise  = lat_s & ~lat_hist;

  assign rx_busy = (state == ARMED) || (state == SHIFT);
  assign timeout = (tmr == TW'(TIMEOUT - 1)) && !sclk_rise;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    done_n   = frame_done;
    shift_en = 1'b0;
    capture  = 1'b0;
    short_p  = 1'b0;
    over_p   = 1'b0;
    // A latch edge always wins, discarding any coincident sclk edge.
    if (lat_rise) begin
      state_n = ARMED;
      cnt_n   = '0;
      done_n  = 1'b0;
      short_p = (state == SHIFT);
    end else begin
      case (state)
        IDLE: begin
          if (sclk_rise && frame_done) begin
            over_p  = 1'b1;
            done_n  = 1'b0;
            state_n = OVER;
          end
        end
        ARMED: begin
          if (sclk_rise) begin
            shift_en = 1'b1;
            cnt_n    = CW'(1);
            state_n  = SHIFT;
          end else if (timeout) begin
            state_n = IDLE;
          end
        end
        SHIFT: begin
          if (sclk_rise) begin
            shift_en = 1'b1;
            if (cnt == CW'(WIDTH - 1)) begin
              capture = 1'b1;
              cnt_n   = '0;
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end else if (timeout) begin
            short_p = 1'b1;
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      frame_done   <= 1'b0;
      sr           <= '0;
      tmr          <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_short_err <= 1'b0;
      rx_over_err  <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      frame_done   <= done_n;
      rx_valid     <= capture;
      rx_short_err <= short_p;
      rx_over_err  <= over_p;
      if (shift_en)
        sr <= {sr[WIDTH-2:0], sin_s};
      // Capture takes the in-flight bit directly so rx_valid lands one cycle after the edge.
      if (capture) begin
        rx_data   <= {sr[WIDTH-2:0], sin_s};
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (lat_rise || sclk_rise || !rx_busy)
        tmr <= '0;
      else if (tmr != TW'(TIMEOUT - 1))
        tmr <= tmr + TW'(1);
    end
  end

endmodule

// File: tb/tb_disp_sr_rx.sv
// Randomized self-checking bench for disp_sr_rx against a bit-queue frame model.
module tb_disp_sr_rx;
  localparam int WIDTH = 256;
  localparam int SYNC  = 2;
  localparam int TMO   = 1024;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             disp_sclk = 1'b0;
  logic             disp_lat = 1'b0;
  logic             disp_sin = 1'b0;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid, rx_short_err, rx_over_err, rx_busy;
  logic [15:0]      frame_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_valid = 0, n_short = 0, n_over = 0;
  int valid_cyc = 0, short_cyc = 0, last_rise_cyc = 0;

  logic [WIDTH-1:0] exp_data = '0;
  int               exp_cnt = 0;
  bit               q[$];

  disp_sr_rx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .disp_sclk(disp_sclk), .disp_lat(disp_lat), .disp_sin(disp_sin),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_short_err(rx_short_err),
    .rx_over_err(rx_over_err), .rx_busy(rx_busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin n_valid++; valid_cyc = cyc; end
      if (rx_short_err) begin n_short++; short_cyc = cyc; end
      if (rx_over_err) n_over++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit, got no finish, required finish");
    $fatal(1);
  end

  // Model: the first received bit is the MSB of the word.
  function automatic logic [WIDTH-1:0] pack_bits();
    logic [WIDTH-1:0] w = '0;
    foreach (q[i]) if (q[i]) w[WIDTH-1-i] = 1'b1;
    return w;
  endfunction

  task automatic send_bit(input bit b, input int half);
    disp_sin = b;
    repeat (half) @(negedge clk);
    disp_sclk = 1'b1;
    last_rise_cyc = cyc;
    repeat (half) @(negedge clk);
    disp_sclk = 1'b0;
  endtask

  task automatic send_rand(input int n, input int half);
    bit b;
    q.delete();
    for (int i = 0; i < n; i++) begin
      b = 1'($urandom_range(0, 1));
      q.push_back(b);
      send_bit(b, half);
    end
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w, input int half);
    q.delete();
    for (int i = 0; i < WIDTH; i++) begin
      q.push_back(w[WIDTH-1-i]);
      send_bit(w[WIDTH-1-i], half);
    end
  endtask

  task automatic lat_pulse();
    disp_lat = 1'b1;
    repeat (4) @(negedge clk);
    disp_lat = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({rx_data, rx_valid, rx_short_err, rx_over_err, rx_busy, frame_cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs: got data=%h busy=%b cnt=%0d, required all zero", rx_data, rx_busy, frame_cnt);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (rx_busy !== 1'b0 || frame_cnt !== 16'd0) begin
      bad++; $display("FAIL post_reset_idle: got busy=%b cnt=%0d, required 0/0", rx_busy, frame_cnt);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] w = '0;
    int v0 = n_valid, s0 = n_short, o0 = n_over, lat;
    w[7:0] = 8'h1C; w[15:8] = 8'hCE; w[23:16] = 8'hBC;
    lat_pulse();
    total++;
    if (rx_busy !== 1'b1) begin bad++; $display("FAIL armed_busy: got %b, required 1", rx_busy); end
    send_word(w, 25);
    settle();
    exp_data = pack_bits(); exp_cnt++;
    total++;
    if (n_valid - v0 != 1) begin bad++; $display("FAIL basic_valid_count: got %0d, required 1", n_valid - v0); end
    total++;
    if (rx_data !== exp_data) begin bad++; $display("FAIL basic_data: got %h, required %h", rx_data, exp_data); end
    total++;
    if (frame_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL basic_frame_cnt: got %0d, required %0d", frame_cnt, exp_cnt); end
    total++;
    if (n_short != s0 || n_over != o0) begin bad++; $display("FAIL basic_no_err: got short=%0d over=%0d, required none", n_short - s0, n_over - o0); end
    lat = valid_cyc - last_rise_cyc;
    total++;
    if (lat < SYNC + 1 || lat > SYNC + 2) begin bad++; $display("FAIL capture_latency: got %0d, required %0d..%0d", lat, SYNC + 1, SYNC + 2); end
    total++;
    if (rx_busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b, required 0", rx_busy); end
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    lat_pulse();
    send_word({WIDTH{1'b1}}, 4);
    lat_pulse();
    send_word({(WIDTH/8){8'hAA}}, 4);
    settle();
    exp_data = pack_bits(); exp_cnt += 2;
    total++;
    if (n_valid - v0 != 2) begin bad++; $display("FAIL b2b_valid_count: got %0d, required 2", n_valid - v0); end
    total++;
    if (rx_data !== exp_data) begin bad++; $display("FAIL b2b_data: got %h, required %h", rx_data, exp_data); end
    total++;
    if (frame_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL b2b_frame_cnt: got %0d, required %0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 3; k++) begin
      lat_pulse();
      send_rand(WIDTH, 4);
      settle();
      exp_data = pack_bits(); exp_cnt++;
      total++;
      if (rx_data !== exp_data || frame_cnt !== 16'(exp_cnt)) begin
        bad++; $display("FAIL rand_frame%0d: got %h cnt=%0d, required %h cnt=%0d", k, rx_data, frame_cnt, exp_data, exp_cnt);
      end
    end
  endtask

  task automatic test_short();
    int v0 = n_valid, s0 = n_short;
    lat_pulse();
    send_rand(100, 4);
    lat_pulse();
    settle();
    total++;
    if (n_short - s0 != 1) begin bad++; $display("FAIL short_lat_err: got %0d pulses, required 1", n_short - s0); end
    total++;
    if (n_valid != v0 || rx_data !== exp_data) begin bad++; $display("FAIL short_no_capture: got valid=%0d data=%h, required 0 and %h", n_valid - v0, rx_data, exp_data); end
    send_rand(WIDTH, 4);
    settle();
    exp_data = pack_bits(); exp_cnt++;
    total++;
    if (rx_data !== exp_data || frame_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL short_recover: got %h cnt=%0d, required %h cnt=%0d", rx_data, frame_cnt, exp_data, exp_cnt); end
  endtask

  task automatic test_over();
    int o0;
    lat_pulse();
    send_rand(WIDTH, 4);
    exp_data = pack_bits(); exp_cnt++;
    o0 = n_over;
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 4);
    settle();
    total++;
    if (n_over - o0 != 1) begin bad++; $display("FAIL over_err_once: got %0d pulses, required 1", n_over - o0); end
    total++;
    if (rx_data !== exp_data || frame_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL over_data_hold: got %h cnt=%0d, required %h cnt=%0d", rx_data, frame_cnt, exp_data, exp_cnt); end
    lat_pulse();
    send_rand(WIDTH, 4);
    settle();
    exp_data = pack_bits(); exp_cnt++;
    total++;
    if (rx_data !== exp_data || n_over - o0 != 1) begin bad++; $display("FAIL over_recover: got %h over=%0d, required %h over=1", rx_data, n_over - o0, exp_data); end
  endtask

  task automatic test_lat_sclk_collide();
    int v0, s0;
    lat_pulse();
    send_rand(WIDTH - 1, 4);
    v0 = n_valid; s0 = n_short;
    disp_sin = 1'($urandom_range(0, 1));
    repeat (4) @(negedge clk);
    disp_sclk = 1'b1; disp_lat = 1'b1;
    repeat (4) @(negedge clk);
    disp_sclk = 1'b0;
    repeat (4) @(negedge clk);
    disp_lat = 1'b0;
    settle();
    total++;
    if (n_short - s0 != 1 || n_valid != v0) begin bad++; $display("FAIL collide_lat_wins: got short=%0d valid=%0d, required 1/0", n_short - s0, n_valid - v0); end
    total++;
    if (rx_data !== exp_data) begin bad++; $display("FAIL collide_data_hold: got %h, required %h", rx_data, exp_data); end
    send_rand(WIDTH, 4);
    settle();
    exp_data = pack_bits(); exp_cnt++;
    total++;
    if (rx_data !== exp_data || frame_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL collide_recover: got %h cnt=%0d, required %h cnt=%0d", rx_data, frame_cnt, exp_data, exp_cnt); end
  endtask

  task automatic test_timeout();
    int s0, gap;
    lat_pulse();
    send_rand(10, 4);
    s0 = n_short;
    repeat (1100) @(negedge clk);
    gap = short_cyc - last_rise_cyc;
    total++;
    if (n_short - s0 != 1) begin bad++; $display("FAIL timeout_err: got %0d pulses, required 1", n_short - s0); end
    total++;
    if (gap < TMO || gap > TMO + SYNC + 3) begin bad++; $display("FAIL timeout_delay: got %0d, required %0d..%0d", gap, TMO, TMO + SYNC + 3); end
    total++;
    if (rx_busy !== 1'b0 || rx_data !== exp_data) begin bad++; $display("FAIL timeout_idle: got busy=%b data=%h, required 0 and %h", rx_busy, rx_data, exp_data); end
    s0 = n_short;
    lat_pulse();
    repeat (1100) @(negedge clk);
    total++;
    if (n_short != s0 || rx_busy !== 1'b0) begin bad++; $display("FAIL armed_timeout: got short=%0d busy=%b, required 0/0", n_short - s0, rx_busy); end
  endtask

  task automatic test_reset_mid();
    int v0;
    lat_pulse();
    send_rand(128, 4);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({rx_data, rx_valid, rx_short_err, rx_over_err, rx_busy, frame_cnt} !== '0) begin
      bad++; $display("FAIL midreset_outputs: got data=%h busy=%b cnt=%0d, required all zero", rx_data, rx_busy, frame_cnt);
    end
    rst_n = 1'b1;
    exp_data = '0; exp_cnt = 0;
    v0 = n_valid;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 4);
    settle();
    total++;
    if (n_valid != v0 || rx_busy !== 1'b0 || frame_cnt !== 16'd0) begin bad++; $display("FAIL midreset_needs_lat: got valid=%0d busy=%b, required 0/0", n_valid - v0, rx_busy); end
    lat_pulse();
    send_rand(WIDTH, 4);
    settle();
    exp_data = pack_bits(); exp_cnt++;
    total++;
    if (rx_data !== exp_data || frame_cnt !== 16'(exp_cnt) || n_valid - v0 != 1) begin
      bad++; $display("FAIL midreset_frame: got %h cnt=%0d, required %h cnt=%0d", rx_data, frame_cnt, exp_data, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random_frames();
    test_short();
    test_over();
    test_lat_sclk_collide();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
